// File: rtl/cell_block_energy_window.sv
// -----------------------------------------------------------------------------
// cell_block_energy_window
//
// Sits after the per-cell sum-of-squares stage of the HOG normalisation path.
// Cell energies arrive one per accepted sos_valid, in raster order. A single
// cell-row line buffer holds the previous row. Two left-neighbour registers hold
// the cell to the left in the current row and in the row above. Together they
// form the 2x2 block energy
//   E(r-1,c-1) + E(r-1,c) + E(r,c-1) + E(r,c)
// which is emitted one cycle after cell (r,c) is accepted, for r>=1 and c>=1.
// The block is reported at position (r-1,c-1).
//
// Ports
//   aclk            clock
//   arest_n         asynchronous active-low reset
//   frame_start     one-cycle pulse: start a new frame (clears counters/overrun)
//   sos_valid       cell energy valid, one-cycle pulse per cell
//   sum_of_squares  unsigned cell energy, TOTAL_BIT_WIDTH bits
//   block_valid     one-cycle pulse with each block sum
//   block_sum       unsigned 2x2 block energy, TOTAL_BIT_WIDTH+2 bits
//   block_row       block row index, 0..CELLS_H-2
//   block_col       block column index, 0..CELLS_W-2
//   frame_done      one-cycle pulse together with the last block of a frame
//   overrun         sticky: a cell arrived after the frame was complete
// -----------------------------------------------------------------------------
module cell_block_energy_window #(
   parameter int TOTAL_BIT_WIDTH = 35,
   parameter int CELLS_W         = 32,
   parameter int CELLS_H         = 32,
   // Historical simulation-only NBA delay; the logic here is zero-delay.
   parameter int DELAY           = 1
) (
   input  logic                       aclk,
   input  logic                       arest_n,
   input  logic                       frame_start,
   input  logic                       sos_valid,
   input  logic [TOTAL_BIT_WIDTH-1:0] sum_of_squares,
   output logic                       block_valid,
   output logic [TOTAL_BIT_WIDTH+1:0] block_sum,
   output logic [5:0]                 block_row,
   output logic [5:0]                 block_col,
   output logic                       frame_done,
   output logic                       overrun
);

   localparam int         SUM_W        = TOTAL_BIT_WIDTH + 2;
   localparam int         ADDR_W       = (CELLS_W > 1) ? $clog2(CELLS_W) : 1;
   localparam logic [5:0] COL_LAST     = 6'(CELLS_W - 1);
   localparam logic [5:0] ROW_LAST     = 6'(CELLS_H - 1);
   localparam int         DELAY_UNUSED = DELAY;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   // Four unsigned operands, zero-extended so the sum can never wrap.
   function automatic logic [SUM_W-1:0] block_add(
      input logic [TOTAL_BIT_WIDTH-1:0] a,
      input logic [TOTAL_BIT_WIDTH-1:0] b,
      input logic [TOTAL_BIT_WIDTH-1:0] c,
      input logic [TOTAL_BIT_WIDTH-1:0] d
   );
      block_add = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
   endfunction

   // Control state
   state_t     state_q, state_d;
   logic [5:0] row_q, row_d;
   logic [5:0] col_q, col_d;
   logic       overrun_q, overrun_d;

   // Datapath state
   logic [TOTAL_BIT_WIDTH-1:0] linebuf_q [CELLS_W];
   logic [TOTAL_BIT_WIDTH-1:0] cur_left_q, cur_left_d;
   logic [TOTAL_BIT_WIDTH-1:0] up_left_q, up_left_d;

   // Output registers
   logic             block_valid_q, block_valid_d;
   logic [SUM_W-1:0] block_sum_q, block_sum_d;
   logic [5:0]       block_row_q, block_row_d;
   logic [5:0]       block_col_q, block_col_d;
   logic             frame_done_q, frame_done_d;

   // Decode of the current cell
   logic [5:0]                 row_cur;
   logic [5:0]                 col_cur;
   logic                       accept;
   logic                       last_cell;
   logic                       emit;
   logic [TOTAL_BIT_WIDTH-1:0] lb_rd;

   // A frame_start coinciding with sos_valid makes that sample cell (0,0) of
   // the new frame. The position is therefore taken from a cleared counter
   // that same cycle.
   always_comb begin
      row_cur   = frame_start ? 6'd0 : row_q;
      col_cur   = frame_start ? 6'd0 : col_q;
      accept    = sos_valid && (frame_start || (state_q == ST_RUN));
      last_cell = (row_cur == ROW_LAST) && (col_cur == COL_LAST);
      emit      = accept && (row_cur != 6'd0) && (col_cur != 6'd0);
   end

   // Read-before-write: this is E(r-1,c) until the write at the clock edge.
   assign lb_rd = linebuf_q[col_cur[ADDR_W-1:0]];

   // Next-state: frame_start always restarts. Accepting the last cell
   // completes the frame.
   always_comb begin
      state_d = state_q;
      if (accept && last_cell) begin
         state_d = ST_DONE;
      end else if (frame_start) begin
         state_d = ST_RUN;
      end
   end

   // Position counters and sticky overrun
   always_comb begin
      row_d     = row_cur;
      col_d     = col_cur;
      overrun_d = overrun_q;
      if (accept) begin
         if (col_cur == COL_LAST) begin
            col_d = 6'd0;
            row_d = (row_cur == ROW_LAST) ? 6'd0 : row_cur + 6'd1;
         end else begin
            col_d = col_cur + 6'd1;
         end
      end
      if (frame_start) begin
         overrun_d = 1'b0;
      end else if ((state_q == ST_DONE) && sos_valid) begin
         overrun_d = 1'b1;
      end
   end

   // Left neighbours and block output. cur_left/up_left carry stale values
   // across a row wrap, which is harmless because column 0 never emits.
   always_comb begin
      cur_left_d    = cur_left_q;
      up_left_d     = up_left_q;
      block_valid_d = emit;
      frame_done_d  = emit && last_cell;
      block_sum_d   = block_sum_q;
      block_row_d   = block_row_q;
      block_col_d   = block_col_q;
      if (accept) begin
         cur_left_d = sum_of_squares;
         up_left_d  = lb_rd;
      end
      if (emit) begin
         block_sum_d = block_add(up_left_q, lb_rd, cur_left_q, sum_of_squares);
         block_row_d = row_cur - 6'd1;
         block_col_d = col_cur - 6'd1;
      end
   end

   always_ff @(posedge aclk or negedge arest_n) begin
      if (!arest_n) begin
         state_q       <= ST_IDLE;
         row_q         <= '0;
         col_q         <= '0;
         overrun_q     <= 1'b0;
         cur_left_q    <= '0;
         up_left_q     <= '0;
         block_valid_q <= 1'b0;
         block_sum_q   <= '0;
         block_row_q   <= '0;
         block_col_q   <= '0;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         row_q         <= row_d;
         col_q         <= col_d;
         overrun_q     <= overrun_d;
         cur_left_q    <= cur_left_d;
         up_left_q     <= up_left_d;
         block_valid_q <= block_valid_d;
         block_sum_q   <= block_sum_d;
         block_row_q   <= block_row_d;
         block_col_q   <= block_col_d;
         frame_done_q  <= frame_done_d;
      end
   end

   // Line buffer is never read before it is written within a frame, so it
   // carries no reset.
   always_ff @(posedge aclk) begin
      if (accept) begin
         linebuf_q[col_cur[ADDR_W-1:0]] <= sum_of_squares;
      end
   end

   assign block_valid = block_valid_q;
   assign block_sum   = block_sum_q;
   assign block_row   = block_row_q;
   assign block_col   = block_col_q;
   assign frame_done  = frame_done_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_cell_block_energy_window.sv
module tb_cell_block_energy_window;

   localparam int TW = 35;
   localparam int W  = 32;
   localparam int H  = 32;

   logic          aclk;
   logic          arest_n;
   logic          frame_start;
   logic          sos_valid;
   logic [TW-1:0] sum_of_squares;
   logic          block_valid;
   logic [TW+1:0] block_sum;
   logic [5:0]    block_row;
   logic [5:0]    block_col;
   logic          frame_done;
   logic          overrun;

   cell_block_energy_window #(
      .TOTAL_BIT_WIDTH(TW),
      .CELLS_W(W),
      .CELLS_H(H),
      .DELAY(1)
   ) dut (
      .aclk(aclk),
      .arest_n(arest_n),
      .frame_start(frame_start),
      .sos_valid(sos_valid),
      .sum_of_squares(sum_of_squares),
      .block_valid(block_valid),
      .block_sum(block_sum),
      .block_row(block_row),
      .block_col(block_col),
      .frame_done(frame_done),
      .overrun(overrun)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   longint cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] sum;
      int          row;
      int          col;
      bit          done;
      longint      cyc;
   } exp_t;

   exp_t q[$];

   // Reference model: the whole frame kept as a 2-D array of energies.
   logic [TW-1:0] E [H][W];
   int            m_state = 0;   // 0 idle, 1 collecting, 2 complete
   int            m_r = 0;
   int            m_c = 0;
   bit            m_overrun = 0;

   // Per-phase observations
   int          blk_count = 0;
   int          done_count = 0;
   logic [63:0] sum00 = 0;
   logic [63:0] sum_last = 0;
   bit          done_last = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_fs();
      m_r = 0;
      m_c = 0;
      m_state = 1;
      m_overrun = 0;
   endtask

   task automatic model_cell(input logic [TW-1:0] v, input bit fs);
      exp_t e;
      if (fs) model_fs();
      if (m_state == 1) begin
         E[m_r][m_c] = v;
         if (m_r > 0 && m_c > 0) begin
            e.sum  = 64'(E[m_r-1][m_c-1]) + 64'(E[m_r-1][m_c]) + 64'(E[m_r][m_c-1]) + 64'(v);
            e.row  = m_r - 1;
            e.col  = m_c - 1;
            e.done = (m_r == H-1) && (m_c == W-1);
            e.cyc  = cyc + 1;
            q.push_back(e);
         end
         if (m_c == W-1) begin
            m_c = 0;
            m_r++;
         end else begin
            m_c++;
         end
         if (m_r == H) m_state = 2;
      end else if (m_state == 2) begin
         m_overrun = 1;
      end
   endtask

   // Called at posedge+1; drives one cell for one cycle then idles `gap` cycles.
   task automatic drive_cell(input logic [TW-1:0] v, input bit fs, input int gap);
      sos_valid = 1'b1;
      sum_of_squares = v;
      frame_start = fs;
      model_cell(v, fs);
      @(posedge aclk); #1;
      sos_valid = 1'b0;
      frame_start = 1'b0;
      repeat (gap) begin
         @(posedge aclk); #1;
      end
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      model_fs();
      @(posedge aclk); #1;
      frame_start = 1'b0;
      @(posedge aclk); #1;
   endtask

   // mode 0: r*W+c, 1: all ones, 2: random, 3: constant 1
   task automatic send_cells(input int mode, input int gmin, input int gmax, input int n, input bit fs_first);
      logic [63:0] rnd;
      logic [TW-1:0] v;
      for (int i = 0; i < n; i++) begin
         rnd = {$urandom(), $urandom()};
         case (mode)
            0:       v = TW'(i);
            1:       v = '1;
            2:       v = rnd[TW-1:0];
            default: v = TW'(1);
         endcase
         drive_cell(v, fs_first && (i == 0), int'($urandom_range(gmax, gmin)));
      end
   endtask

   task automatic new_phase();
      blk_count = 0;
      done_count = 0;
   endtask

   task automatic drain();
      repeat (4) begin
         @(posedge aclk); #1;
      end
      chk("queue_empty", 64'(q.size()), 64'd0);
   endtask

   // Monitor / scoreboard
   always @(negedge aclk) begin
      exp_t e;
      if (block_valid || frame_done) begin
         if (!block_valid) begin
            checks++;
            errors++;
            $display("FAIL frame_done_without_block: frame_done=1 block_valid=0, required both");
         end else if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_block: got row=%0d col=%0d sum=%0h, expected no block", block_row, block_col, block_sum);
         end else begin
            e = q.pop_front();
            checks++;
            blk_count++;
            if (frame_done) done_count++;
            if (block_row == 0 && block_col == 0) sum00 = 64'(block_sum);
            if (block_row == 6'(H-2) && block_col == 6'(W-2)) begin
               sum_last = 64'(block_sum);
               done_last = frame_done;
            end
            if (64'(block_sum) !== e.sum || int'(block_row) != e.row || int'(block_col) != e.col ||
                frame_done !== e.done || cyc != e.cyc) begin
               errors++;
               $display("FAIL block: got sum=%0h row=%0d col=%0d done=%0b cyc=%0d, expected sum=%0h row=%0d col=%0d done=%0b cyc=%0d",
                        block_sum, block_row, block_col, frame_done, cyc, e.sum, e.row, e.col, e.done, e.cyc);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      arest_n = 1'b0;
      frame_start = 1'b0;
      sos_valid = 1'b0;
      sum_of_squares = '0;
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_block_valid", 64'(block_valid), 0);
      chk("rst_block_sum", 64'(block_sum), 0);
      chk("rst_block_row", 64'(block_row), 0);
      chk("rst_block_col", 64'(block_col), 0);
      chk("rst_frame_done", 64'(frame_done), 0);
      chk("rst_overrun", 64'(overrun), 0);
      arest_n = 1'b1;
      @(posedge aclk); #1;

      // Cells in IDLE are ignored
      drive_cell(TW'(5), 0, 2);
      drive_cell(TW'(6), 0, 2);
      chk("idle_overrun", 64'(overrun), 0);

      // Basic: one cell every 9 cycles
      new_phase();
      pulse_fs();
      send_cells(0, 8, 8, W*H, 0);
      drain();
      chk("basic_blocks", 64'(blk_count), 961);
      chk("basic_done_count", 64'(done_count), 1);
      chk("basic_sum00", sum00, 64'd66);
      chk("basic_sum_last", sum_last, 64'd4026);
      chk("basic_done_last", 64'(done_last), 1);

      // Overrun after a complete frame
      new_phase();
      drive_cell(TW'(7), 0, 3);
      chk("overrun_set", 64'(overrun), 1);
      chk("overrun_no_block", 64'(blk_count), 0);
      pulse_fs();
      chk("overrun_cleared", 64'(overrun), 0);

      // Back-to-back (frame already started by the pulse above)
      new_phase();
      send_cells(0, 0, 0, W*H, 0);
      drain();
      chk("b2b_blocks", 64'(blk_count), 961);
      chk("b2b_done_count", 64'(done_count), 1);
      chk("b2b_sum00", sum00, 64'd66);
      chk("b2b_sum_last", sum_last, 64'd4026);

      // Full-scale operands
      new_phase();
      pulse_fs();
      send_cells(1, 0, 2, W*H, 0);
      drain();
      chk("width_blocks", 64'(blk_count), 961);
      chk("width_sum00", sum00, 64'h1F_FFFF_FFFC);
      chk("width_sum_last", sum_last, 64'h1F_FFFF_FFFC);

      // Random energies and gaps
      new_phase();
      pulse_fs();
      send_cells(2, 0, 3, W*H, 0);
      drain();
      chk("rand_blocks", 64'(blk_count), 961);
      chk("rand_done_count", 64'(done_count), 1);

      // Restart: 100-cell partial frame, then a frame with coincident start
      new_phase();
      pulse_fs();
      send_cells(2, 0, 0, 100, 0);
      send_cells(3, 0, 0, W*H, 1);
      drain();
      chk("restart_blocks", 64'(blk_count), 65 + 961);
      chk("restart_done_count", 64'(done_count), 1);
      chk("restart_sum00", sum00, 64'd4);
      chk("restart_sum_last", sum_last, 64'd4);

      // Asynchronous reset mid-frame
      pulse_fs();
      send_cells(2, 1, 1, 40, 0);
      #3;
      arest_n = 1'b0;
      #1;
      chk("arst_block_valid", 64'(block_valid), 0);
      chk("arst_block_sum", 64'(block_sum), 0);
      chk("arst_block_row", 64'(block_row), 0);
      chk("arst_block_col", 64'(block_col), 0);
      chk("arst_frame_done", 64'(frame_done), 0);
      q.delete();
      m_state = 0;
      m_overrun = 0;
      @(posedge aclk); #1;
      @(posedge aclk); #1;
      arest_n = 1'b1;
      @(posedge aclk); #1;
      new_phase();
      send_cells(2, 0, 1, 40, 0);
      drain();
      chk("arst_ignored_blocks", 64'(blk_count), 0);
      chk("arst_overrun", 64'(overrun), 0);
      new_phase();
      pulse_fs();
      send_cells(2, 0, 0, W*H, 0);
      drain();
      chk("arst_next_blocks", 64'(blk_count), 961);
      chk("arst_next_done", 64'(done_count), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
